// File: rtl/imm_packer.sv
// Immediate packer: classifies an immediate by control-unit op and queues it in a 2-deep FIFO.
// Define IMM_PACKER_RANGE_CHECK_EN to flag immediates that do not fit their encoding.
module imm_packer (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_cuop,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_field,
  output logic [5:0]  out_cuop,
  output logic        out_err,
  output logic [7:0]  err_count
);

`ifdef IMM_PACKER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  typedef struct packed {
    logic [19:0] field;
    logic [5:0]  cuop;
    logic        err;
  } beat_t;

  beat_t pk;
  beat_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  logic is_u, is_j, is_b, is_i, is_sh, is_r;
  logic fit12, fit13, fit21;

  assign is_u  = in_cuop <= 6'd1;
  assign is_j  = in_cuop == 6'd2;
  assign is_b  = in_cuop >= 6'd4 && in_cuop <= 6'd9;
  assign is_i  = in_cuop == 6'd3 ||
                 (in_cuop >= 6'd10 && in_cuop <= 6'd24);
  assign is_sh = in_cuop >= 6'd25 && in_cuop <= 6'd27;
  assign is_r  = in_cuop >= 6'd28 && in_cuop <= 6'd37;

  // Signed fit: all bits above the top field bit equal the sign bit.
  assign fit12 = &in_imm[31:11] | ~|in_imm[31:11];
  assign fit13 = &in_imm[31:12] | ~|in_imm[31:12];
  assign fit21 = &in_imm[31:20] | ~|in_imm[31:20];

  always_comb begin
    pk      = '0;
    pk.cuop = in_cuop;
    unique case (1'b1)
      is_u: begin
        pk.field = in_imm[31:12];
        pk.err   = RC & (|in_imm[11:0]);
      end
      is_j: begin
        pk.field = in_imm[20:1];
        pk.err   = RC & (~fit21 | in_imm[0]);
      end
      is_b: begin
        pk.field = {8'b0, in_imm[12:1]};
        pk.err   = RC & (~fit13 | in_imm[0]);
      end
      is_i: begin
        pk.field = {8'b0, in_imm[11:0]};
        pk.err   = RC & ~fit12;
      end
      is_sh: begin
        pk.field = {15'b0, in_imm[4:0]};
        pk.err   = RC & (|in_imm[31:5]);
      end
      is_r: begin
        pk.field = '0;
        pk.err   = 1'b0;
      end
      default: begin
        pk.field = '0;
        pk.err   = 1'b1;
      end
    endcase
  end

  assign full     = count == 2'd2;
  assign empty    = count == 2'd0;
  assign in_ready = ~full;
  assign out_valid = ~empty;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  assign out_field = mem[rd_ptr].field;
  assign out_cuop  = mem[rd_ptr].cuop;
  assign out_err   = mem[rd_ptr].err;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      err_count <= 8'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pk;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && pk.err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_packer.sv
// Directed bench for imm_packer: packing, FIFO flow control,
// error counting and asynchronous reset.
module tb_imm_packer;

`ifdef IMM_PACKER_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_cuop;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_field;
  logic [5:0]  out_cuop;
  logic        out_err;
  logic [7:0]  err_count;

  int total = 0;
  int passed = 0;
  int fails = 0;
  logic [7:0] ec = 8'd0;

  imm_packer dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cuop   (in_cuop),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_cuop  (out_cuop),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag,
                      input logic [5:0] c,
                      input logic [31:0] imm,
                      input logic [19:0] f,
                      input logic e);
    in_cuop  = c;
    in_imm   = imm;
    in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    if (e && ec != 8'hFF) ec++;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".field"}, 32'(out_field), 32'(f));
    chk({tag, ".cuop"}, 32'(out_cuop), 32'(c));
    chk({tag, ".err"}, 32'(out_err), 32'(e));
    step();
    chk({tag, ".drain"}, 32'(out_valid), 32'd0);
    chk({tag, ".errcnt"}, 32'(err_count), 32'(ec));
  endtask

  initial begin
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_cuop   = 6'd0;
    in_imm    = 32'd0;
    out_ready = 1'b1;
    #2;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.field", 32'(out_field), 32'd0);
    chk("rst.cuop", 32'(out_cuop), 32'd0);
    chk("rst.err", 32'(out_err), 32'd0);
    chk("rst.errcnt", 32'(err_count), 32'd0);
    step();
    @(negedge clk);
    nrst = 1'b1;
    step();

    send("lui",   6'd0,  32'hCCCCC000, 20'hCCCCC, 1'b0);
    send("jal",   6'd2,  32'hFFF99998, 20'hCCCCC, 1'b0);
    send("sh",    6'd16, 32'hFFFFFCCC, 20'h00CCC, 1'b0);
    send("addi",  6'd18, 32'h000007FF, 20'h007FF, 1'b0);
    send("beq",   6'd4,  32'hFFFFF000, 20'h00800, 1'b0);
    send("jalr",  6'd3,  32'hFFFFFFFF, 20'h00FFF, 1'b0);
    send("add",   6'd28, 32'h12345678, 20'h00000, 1'b0);
    send("error", 6'd38, 32'h0000FFFF, 20'h00000, 1'b1);
    send("op50",  6'd50, 32'h00000123, 20'h00000, 1'b1);
    send("srai",  6'd27, 32'h00000405, 20'h00005, RC);
    send("addi2k",6'd18, 32'h00000800, 20'h00800, RC);
    send("beq3",  6'd4,  32'h00000003, 20'h00001, RC);
    send("auipc", 6'd1,  32'h12345678, 20'h12345, RC);

    // Backpressure: three beats against a stalled consumer.
    out_ready = 1'b0;
    in_cuop   = 6'd18;
    in_valid  = 1'b1;
    in_imm    = 32'd1;
    step();
    chk("bp.rdy1", 32'(in_ready), 32'd1);
    chk("bp.head1", 32'(out_field), 32'd1);
    in_imm = 32'd2;
    step();
    chk("bp.rdy2", 32'(in_ready), 32'd0);
    in_imm = 32'd3;
    step();
    chk("bp.hold", 32'(out_field), 32'd1);
    chk("bp.full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    chk("bp.nopush", 32'(in_ready), 32'd0);
    step();
    chk("bp.head2", 32'(out_field), 32'd2);
    chk("bp.rdy3", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp.head3", 32'(out_field), 32'd3);
    step();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Steady push+pop at occupancy one.
    in_valid = 1'b1;
    in_imm   = 32'h10;
    step();
    for (int i = 1; i <= 10; i++) begin
      in_imm = 32'h10 + 32'(i);
      chk("sim.valid", 32'(out_valid), 32'd1);
      chk("sim.ready", 32'(in_ready), 32'd1);
      chk("sim.head", 32'(out_field), 32'h10 + 32'(i) - 32'd1);
      step();
    end
    in_valid = 1'b0;
    chk("sim.last", 32'(out_field), 32'h1A);
    step();
    chk("sim.empty", 32'(out_valid), 32'd0);

    // Error counter saturation.
    in_cuop  = 6'd38;
    in_imm   = 32'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    step();
    chk("sat.errcnt", 32'(err_count), 32'd255);

    // Reset with two entries queued.
    out_ready = 1'b0;
    in_cuop   = 6'd18;
    in_imm    = 32'h55;
    in_valid  = 1'b1;
    step();
    step();
    chk("mid.full", 32'(in_ready), 32'd0);
    nrst = 1'b0;
    #1;
    chk("mid.valid", 32'(out_valid), 32'd0);
    chk("mid.ready", 32'(in_ready), 32'd1);
    chk("mid.errcnt", 32'(err_count), 32'd0);
    chk("mid.field", 32'(out_field), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    in_imm = 32'h66;
    step();
    in_valid = 1'b0;
    chk("post.valid", 32'(out_valid), 32'd1);
    chk("post.field", 32'(out_field), 32'h66);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
